// File: rtl/packet_parser_stream.sv
// packet_parser_stream
//   Splits wide input lines into a stream of ELEM_W-bit elements through an
//   output FIFO. Each line carries up to NUM_ELEM elements packed from the LSB.
//   A single marker bit at position n*ELEM_W, with every bit above it clear,
//   gives the element count n. Lines with no valid marker are dropped and
//   counted.
//
//   Optional feature: define PACKET_PARSER_CLEAR_CMD_EN to treat a line whose
//   low (NUM_ELEM-2)*ELEM_W bits are all ones as a clear command. Such a line
//   emits one word {clear=1, last=0, data=argument}.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   rx_TDATA   input line: NUM_ELEM elements plus end marker bit
//   rx_TVALID  input line valid
//   rx_TREADY  input line accepted when high together with rx_TVALID
//   tx_TDATA   output word {clear, last, data}
//   tx_TVALID  output word valid
//   tx_TREADY  downstream ready
//   drop_cnt   dropped-line counter, saturating at 16'hFFFF
module packet_parser_stream #(
  parameter int ELEM_W         = 32,
  parameter int NUM_ELEM       = 16,
  parameter int FIFO_ADDR_BITS = 4,
  parameter int CLEAR_ARG_LSB  = 480,
  parameter int CLEAR_ARG_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_ELEM*ELEM_W:0]   rx_TDATA,
  input  logic                       rx_TVALID,
  output logic                       rx_TREADY,
  output logic [ELEM_W+1:0]          tx_TDATA,
  output logic                       tx_TVALID,
  input  logic                       tx_TREADY,
  output logic [15:0]                drop_cnt
);

  localparam int PAY_W  = NUM_ELEM * ELEM_W;
  localparam int CNT_W  = $clog2(NUM_ELEM + 1);
  localparam int DEPTH  = 1 << FIFO_ADDR_BITS;
  localparam int WORD_W = ELEM_W + 2;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state_q, state_d;

  // Held line: shifted down one element per FIFO write, so the element being
  // emitted is always in the low ELEM_W bits.
  logic [PAY_W-1:0] line_q;
  logic [CNT_W-1:0] rem_q;
  logic             clr_q;

  // ---------------------------------------------------------------------------
  // Line decode
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]       line_n;
  logic                   seen;
  logic                   is_clear;
  logic [CLEAR_ARG_W-1:0] clear_arg;
  logic                   line_ok;
  logic [PAY_W-1:0]       load_pay;
  logic [CNT_W-1:0]       load_n;

  // Priority-encode the highest set bit; the line is valid only if that bit
  // sits exactly on an element boundary at or above ELEM_W.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    line_n = '0;
    seen   = 1'b0;
    for (int b = PAY_W; b >= ELEM_W; b--) begin
      if (!seen && rx_TDATA[b]) begin
        seen = 1'b1;
        if (b % ELEM_W == 0) line_n = CNT_W'(b / ELEM_W);
      end
    end
  end

`ifdef PACKET_PARSER_CLEAR_CMD_EN
  assign is_clear = &rx_TDATA[(NUM_ELEM-2)*ELEM_W-1:0];
`else
  assign is_clear = 1'b0;
`endif

  assign clear_arg = rx_TDATA[CLEAR_ARG_LSB +: CLEAR_ARG_W];
  assign line_ok   = is_clear || (line_n != '0);
  // A clear command is emitted as a one-element line carrying its argument.
  assign load_pay  = is_clear ? PAY_W'(clear_arg) : rx_TDATA[PAY_W-1:0];
  assign load_n    = is_clear ? CNT_W'(1) : line_n;

  // ---------------------------------------------------------------------------
  // Parser FSM
  // ---------------------------------------------------------------------------
  logic ready_int;
  logic accept;
  logic push;
  logic fifo_full;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ready_int = 1'b0;
    push      = 1'b0;
    case (state_q)
      IDLE: ready_int = 1'b1;
      EMIT: begin
        if (!fifo_full) begin
          push = 1'b1;
          // The final element's write cycle also accepts the next line.
          if (rem_q == CNT_W'(1)) begin
            ready_int = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept && line_ok) state_d = EMIT;
  end

  assign rx_TREADY = ready_int && !rst;
  assign accept    = rx_TREADY && rx_TVALID;

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q   <= '0;
      rem_q    <= '0;
      clr_q    <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (accept && line_ok) begin
        line_q <= load_pay;
        rem_q  <= load_n;
        clr_q  <= is_clear;
      end else if (push) begin
        line_q <= line_q >> ELEM_W;
        rem_q  <= rem_q - CNT_W'(1);
      end
      if (accept && !line_ok && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO: DEPTH-entry memory followed by a registered head word
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0]         mem [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR_BITS:0]   count;
  logic                      mem_pop;
  logic                      out_valid;
  logic [WORD_W-1:0]         out_data;
  logic [WORD_W-1:0]         push_word;

  assign push_word = {clr_q, !clr_q && (rem_q == CNT_W'(1)), line_q[ELEM_W-1:0]};
  // Refill the head register whenever it is empty or being consumed.
  assign mem_pop   = (count != '0) && (!out_valid || tx_TREADY);
  // A pop in the same cycle frees a slot, so a full memory can still accept.
  assign fifo_full = (count == (FIFO_ADDR_BITS+1)'(DEPTH)) && !mem_pop;

  // NOTE: the storage array is not reset; only pointers and count need a defined value.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (mem_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        out_data  <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (tx_TREADY) begin
        out_valid <= 1'b0;
      end
      case ({push, mem_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign tx_TDATA  = out_data;
  assign tx_TVALID = out_valid;

endmodule

// File: tb/tb_packet_parser_stream.sv
// tb_packet_parser_stream
//   Self-checking bench for packet_parser_stream (default parameters). A
//   line-level reference model turns every accepted line into its expected
//   output words. A negedge compare process checks each popped word, the
//   hold-while-stalled rule and drop_cnt. Directed scenarios add literal
//   checks; a random phase follows. Honours PACKET_PARSER_CLEAR_CMD_EN.
module tb_packet_parser_stream;

  localparam int EW = 32;
  localparam int NE = 16;
  localparam int LW = NE * EW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] rx_TDATA;
  logic          rx_TVALID;
  logic          rx_TREADY;
  logic [EW+1:0] tx_TDATA;
  logic          tx_TVALID;
  logic          tx_TREADY = 1'b1;
  logic [15:0]   drop_cnt;

  packet_parser_stream dut (
    .clk       (clk),
    .rst       (rst),
    .rx_TDATA  (rx_TDATA),
    .rx_TVALID (rx_TVALID),
    .rx_TREADY (rx_TREADY),
    .tx_TDATA  (tx_TDATA),
    .tx_TVALID (tx_TVALID),
    .tx_TREADY (tx_TREADY),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc;
  int ready_mode = 0;  // 0: always ready, 1: never ready, 2: random

  logic [EW+1:0] exp_q[$];
  logic [EW+1:0] obs_q[$];
  int            obs_cyc[$];
  logic [15:0]   mdrop = '0;
  logic          prev_hold = 1'b0;
  logic [EW+1:0] prev_data;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_TREADY = 1'b1;
      1:       tx_TREADY = 1'b0;
      default: tx_TREADY = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a line yields n elements when (line >> n*EW) == 1 for exactly
  // that n in 1..NE; otherwise it is dropped.
  function automatic void model_accept(input logic [LW-1:0] line);
    int n = 0;
`ifdef PACKET_PARSER_CLEAR_CMD_EN
    if (&line[(NE-2)*EW-1:0]) begin
      exp_q.push_back({1'b1, 1'b0, 16'h0, line[480 +: 16]});
      return;
    end
`endif
    for (int k = 1; k <= NE; k++)
      if ((line >> (k * EW)) == LW'(1)) n = k;
    if (n == 0) begin
      if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
    end else begin
      for (int i = 0; i < n; i++)
        exp_q.push_back({1'b0, (i == n - 1), line[i*EW +: EW]});
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mdrop     = '0;
      prev_hold = 1'b0;
    end else begin
      check("drop_cnt", drop_cnt, mdrop);
      if (prev_hold) check("tx_hold", {tx_TVALID, tx_TDATA}, {1'b1, prev_data});
      if (tx_TVALID && tx_TREADY) begin
        obs_q.push_back(tx_TDATA);
        obs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h expected none", tx_TDATA);
        end else begin
          check("tx_word", tx_TDATA, exp_q.pop_front());
        end
      end
      prev_hold = tx_TVALID && !tx_TREADY;
      prev_data = tx_TDATA;
      if (rx_TVALID && rx_TREADY) model_accept(rx_TDATA);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Call only at posedge+#1; returns at posedge+#1 right after acceptance.
  task automatic send_line(input logic [LW-1:0] line);
    int waited = 0;
    rx_TDATA  = line;
    rx_TVALID = 1'b1;
    @(negedge clk);
    while (!rx_TREADY && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_TREADY) begin
      total++;
      bad++;
      $display("FAIL rx_accept_timeout: got no rx_TREADY expected accept within 300 cycles");
      @(posedge clk);
      #1;
      rx_TVALID = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      rx_TVALID = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_q.size() != 0 || tx_TVALID) && w < 1000) begin
      step();
      w++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  function automatic logic [LW-1:0] data_line(input int n);
    logic [LW-1:0] l = '0;
    for (int i = 0; i < n; i++) l[i*EW +: EW] = $urandom;
    l[n*EW] = 1'b1;
    return l;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l = '0;
    int kind = $urandom_range(0, 9);
    int n;
    if (kind == 0) begin
      l = '0;
    end else if (kind == 1) begin
      n = $urandom_range(1, NE - 1);
      for (int i = 0; i < n; i++) l[i*EW +: EW] = $urandom;
      l[n*EW + $urandom_range(1, EW - 1)] = 1'b1;
    end else if (kind == 2) begin
      l[EW-1:0] = $urandom_range(1, 255);
    end else begin
      l = data_line($urandom_range(1, NE));
    end
    return l;
  endfunction

  initial begin
    logic [LW-1:0] l;
    int            acc1;
    int            e0;

    rst       = 1'b1;
    rx_TVALID = 1'b0;
    rx_TDATA  = '0;
    repeat (3) step();
    sample();
    check("rx_ready_in_reset", rx_TREADY, 0);
    step();
    rst = 1'b0;
    sample();
    check("rx_ready_after_reset", rx_TREADY, 1);
    check("tx_valid_after_reset", tx_TVALID, 0);
    check("tx_data_after_reset", tx_TDATA, 0);
    check("drop_after_reset", drop_cnt, 0);
    step();

    // Three-element line, latency and literal word values.
    obs_q.delete(); obs_cyc.delete();
    l = '0;
    l[31:0] = 32'h11; l[63:32] = 32'h22; l[95:64] = 32'h33; l[96] = 1'b1;
    send_line(l);
    wait_drain();
    check("short_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("short_w0", obs_q[0], 34'h0_0000_0011);
      check("short_w1", obs_q[1], 34'h0_0000_0022);
      check("short_w2", obs_q[2], 34'h1_0000_0033);
      check("short_latency", obs_cyc[0] - acc_cyc, 2);
    end

    // Two back-to-back full lines at full rate.
    obs_q.delete(); obs_cyc.delete();
    send_line(data_line(NE));
    acc1 = acc_cyc;
    send_line(data_line(NE));
    check("b2b_accept_gap", acc_cyc - acc1, 16);
    wait_drain();
    check("b2b_count", obs_q.size(), 32);
    if (obs_q.size() == 32) begin
      check("b2b_span", obs_cyc[31] - obs_cyc[0], 31);
      check("b2b_last0", obs_q[0][EW], 0);
      check("b2b_last16", obs_q[15][EW], 1);
      check("b2b_last17", obs_q[16][EW], 0);
      check("b2b_last32", obs_q[31][EW], 1);
    end

    // Downstream stalled for 40 cycles: buffer fills, parser holds.
    obs_q.delete(); obs_cyc.delete();
    ready_mode = 1;
    step();
    send_line(data_line(NE));
    send_line(data_line(NE));
    repeat (40) step();
    sample();
    check("stall_rx_ready", rx_TREADY, 0);
    check("stall_tx_valid", tx_TVALID, 1);
    check("stall_no_pop", obs_q.size(), 0);
    step();
    ready_mode = 0;
    wait_drain();
    check("stall_count", obs_q.size(), 32);

    // Malformed lines are dropped.
    obs_q.delete(); obs_cyc.delete();
    send_line('0);
    l = '0;
    l[0] = 1'b1; l[500] = 1'b1;
    send_line(l);
    sample();
    check("drop_rx_ready", rx_TREADY, 1);
    check("drop_count2", drop_cnt, 2);
    step();
    repeat (4) step();
    check("drop_no_output", obs_q.size(), 0);

    // Clear-command pattern.
    l = '0;
    l[(NE-2)*EW-1:0] = '1;
    l[495:480] = 16'h000A;
    send_line(l);
    wait_drain();
`ifdef PACKET_PARSER_CLEAR_CMD_EN
    check("clear_count", obs_q.size(), 1);
    if (obs_q.size() == 1) check("clear_word", obs_q[0], 34'h2_0000_000A);
    check("clear_drop", drop_cnt, 2);
`else
    check("clear_as_data_drop", drop_cnt, 3);
    check("clear_as_data_out", obs_q.size(), 0);
`endif

    // Reset in the middle of a 16-element line.
    send_line(data_line(NE));
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    check("midreset_tx_valid", tx_TVALID, 0);
    check("midreset_drop", drop_cnt, 0);
    check("midreset_rx_ready", rx_TREADY, 1);
    step();
    obs_q.delete(); obs_cyc.delete();
    l  = data_line(3);
    e0 = l[EW-1:0];
    send_line(l);
    wait_drain();
    check("midreset_next_count", obs_q.size(), 3);
    if (obs_q.size() == 3) check("midreset_next_w0", obs_q[0], {2'b00, e0[EW-1:0]});

    // Random lines, gaps and downstream back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 250; i++) begin
      send_line(rand_line());
      repeat ($urandom_range(0, 2)) step();
    end
    ready_mode = 0;
    step();
    wait_drain();
    check("model_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
